acc_stream_1p: RTL

- Downstream consumer of the 15-bit two-stage pipelined adder.
- Accumulates a block of blk_len adder results into a 19-bit total.
- Uses the same LSB/MSB split with a registered carry, so no full-width carry chain sits in one cycle.
- Presents the total through a valid/ready output handshake for the next datapath stage.

---
 rtl/add_pkg.sv | 9 +
 rtl/acc_stream_1p_if.sv | 9 +
 rtl/acc_stream_1p_split.sv | 39 +++
 rtl/acc_stream_1p.sv | 55 +++++
 4 files changed

// File: rtl/add_pkg.sv
// add_pkg: shared widths and FSM states for the split-carry adder/accumulator family
package add_pkg;
  localparam int WIDTH = 15;
  localparam int WIDTH1 = 7;
  localparam int GUARD = 4;
  localparam int ACC_W = WIDTH + GUARD;
  localparam int WIDTH2 = ACC_W - WIDTH1;
  typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;
endpackage

// File: rtl/acc_stream_1p_if.sv
// acc_stream_1p_if: sample input and result output handshakes of acc_stream_1p
interface acc_stream_1p_if;
  import add_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic [ACC_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/acc_stream_1p_split.sv
// acc_split_stage: registered LSB add with carry, MSB add one cycle later
module acc_split_stage import add_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);
  logic [WIDTH1-1:0] lsb_acc;
  logic [WIDTH2-1:0] msb_acc, msb_d;
  logic c_q, msb_v;
  logic [WIDTH1:0] lsb_sum;
  logic [WIDTH2:0] msb_sum;
  assign lsb_sum = {1'b0, lsb_acc} + {1'b0, din[WIDTH1-1:0]};
  assign msb_sum = {1'b0, msb_acc} + {1'b0, msb_d} + {{WIDTH2{1'b0}}, c_q};
  assign sum = {msb_acc, lsb_acc};
  assign cout = msb_v & msb_sum[WIDTH2];
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      lsb_acc <= '0;
      msb_acc <= '0;
      msb_d <= '0;
      c_q <= 1'b0;
      msb_v <= 1'b0;
    end else begin
      if (en) begin
        {c_q, lsb_acc} <= lsb_sum;
        msb_d <= {{GUARD{1'b0}}, din[WIDTH-1:WIDTH1]};
        msb_v <= 1'b1;
      end else begin
        c_q <= 1'b0;
        msb_v <= 1'b0;
      end
      if (msb_v) msb_acc <= msb_sum[WIDTH2-1:0];
    end
  end
endmodule

// File: rtl/acc_stream_1p.sv
// acc_stream_1p: accumulates blk_len samples into a 19-bit total; ACC_STREAM_OVF_EN adds sticky ovf
module acc_stream_1p import add_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] blk_len,
  acc_stream_1p_if.slave s,
`ifdef ACC_STREAM_OVF_EN
  output logic       ovf,
`endif
  output logic       busy
);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic acc_en, clr, cout;
  logic [ACC_W-1:0] sum;
  acc_split_stage u_split (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(acc_en),
    .din(s.in_data), .sum(sum), .cout(cout)
  );
  assign acc_en = (state == ACC) && s.in_valid;
  assign clr = (state == IDLE) && start;
  assign s.in_ready = state == ACC;
  assign s.out_valid = state == DONE;
  assign s.out_data = sum;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? ((blk_len == 8'd0) ? DONE : ACC) : IDLE;
      ACC:   state_nx = (acc_en && cnt == 8'd1) ? FLUSH : ACC;
      FLUSH: state_nx = DONE;
      DONE:  state_nx = s.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 8'd0;
    end else begin
      state <= state_nx;
      cnt <= clr ? blk_len : acc_en ? cnt - 8'd1 : cnt;
    end
  end
`ifdef ACC_STREAM_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr) ovf <= 1'b0;
    else if (cout) ovf <= 1'b1;
  end
`else
  logic unused_cout;
  assign unused_cout = cout;
`endif
endmodule
